// File: rtl/bist_pkg.sv
// Shared BIST definitions: MISR feedback polynomial, compactor FSM states
// and pattern counter width.
package bist_pkg;

  localparam logic [15:0] MISR_POLY16 = 16'h100B;  // x^16+x^12+x^3+x+1
  localparam int          PAT_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    DONE    = 2'd2
  } misr_state_e;

endpackage

// File: rtl/misr_core.sv
// Bare multiple-input signature register: shift-left with polynomial feedback
// from the MSB, XORed with the parallel input word.
module misr_core #(
  parameter int              SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig,
  output logic [SIG_W-1:0] sig_nxt
);

  // Exposed so the owner can judge the final signature on the same edge it is captured
  assign sig_nxt = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sig <= '0;
    else if (clr)
      sig <= '0;
    else if (en)
      sig <= sig_nxt;
  end

endmodule

// File: rtl/misr_compactor.sv
// Session controller around misr_core: counts NUM_PAT responses, then compares
// the signature with GOLDEN. Define MISR_XMASK_EN to add the resp_mask X-mask input.
module misr_compactor
  import bist_pkg::*;
#(
  parameter int               SIG_W   = 16,
  parameter int               IN_W    = 7,
  parameter int               NUM_PAT = 1000,
  parameter logic [SIG_W-1:0] GOLDEN  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 resp_valid,
`ifdef MISR_XMASK_EN
  input  logic [IN_W-1:0]      resp_mask,
`endif
  input  logic [IN_W-1:0]      resp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_W-1:0]     signature,
  output logic [PAT_CNT_W-1:0] pat_cnt
);

  localparam logic [PAT_CNT_W-1:0] LAST_IDX = PAT_CNT_W'(NUM_PAT - 1);

  misr_state_e            state, state_nxt;
  logic                   sig_clr, sig_en;
  logic                   pass_nxt;
  logic [PAT_CNT_W-1:0]   cnt_nxt;
  logic [IN_W-1:0]        resp_eff;
  logic [SIG_W-1:0]       sig_nxt;

`ifdef MISR_XMASK_EN
  // Masked positions are forced to zero so unknown bits cannot corrupt the signature
  assign resp_eff = resp & ~resp_mask;
`else
  assign resp_eff = resp;
`endif

  misr_core #(
    .SIG_W (SIG_W),
    .POLY  (SIG_W'(MISR_POLY16))
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .clr     (sig_clr),
    .en      (sig_en),
    .din     (SIG_W'(resp_eff)),
    .sig     (signature),
    .sig_nxt (sig_nxt)
  );

  always_comb begin
    state_nxt = state;
    sig_clr   = 1'b0;
    sig_en    = 1'b0;
    cnt_nxt   = pat_cnt;
    pass_nxt  = pass;
    if (abort) begin
      state_nxt = IDLE;
      pass_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_nxt = COMPACT;
            sig_clr   = 1'b1;
            cnt_nxt   = '0;
            pass_nxt  = 1'b0;
          end
        end
        COMPACT: begin
          if (resp_valid) begin
            sig_en  = 1'b1;
            cnt_nxt = pat_cnt + 1'b1;
            // Final response: verdict taken from the signature being written this edge
            if (pat_cnt == LAST_IDX) begin
              state_nxt = DONE;
              pass_nxt  = (sig_nxt == GOLDEN);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pat_cnt <= '0;
      pass    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pat_cnt <= cnt_nxt;
      pass    <= pass_nxt;
    end
  end

  assign busy = (state == COMPACT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_misr_compactor.sv
// Directed bench for misr_compactor: five instances with different NUM_PAT
// share one stimulus stream; each scenario checks the instance it targets.
module tb_misr_compactor;

  localparam int NPS [5] = '{4, 1, 17, 3, 2};

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, resp_valid;
  logic [6:0]  resp;
`ifdef MISR_XMASK_EN
  logic [6:0]  resp_mask;
`endif
  logic        busy [5];
  logic        done [5];
  logic        pass [5];
  logic [15:0] sig  [5];
  logic [15:0] cnt  [5];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    misr_compactor #(
      .SIG_W   (16),
      .IN_W    (7),
      .NUM_PAT (NPS[g]),
      .GOLDEN  (16'h0000)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .resp_valid (resp_valid),
`ifdef MISR_XMASK_EN
      .resp_mask  (resp_mask),
`endif
      .resp       (resp),
      .busy       (busy[g]),
      .done       (done[g]),
      .pass       (pass[g]),
      .signature  (sig[g]),
      .pat_cnt    (cnt[g])
    );
  end

  task automatic cyc(input logic s, input logic a, input logic v, input logic [6:0] r);
    @(negedge clk);
    start = s; abort = a; resp_valid = v; resp = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if (sig[0] !== 16'h0) begin errors++; $display("FAIL rst_sig got=%h want=0000", sig[0]); end checks++;
    if (cnt[0] !== 16'd0) begin errors++; $display("FAIL rst_cnt got=%0d want=0", cnt[0]); end checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy[0]); end checks++;
    if (done[0] !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", done[0]); end checks++;
    if (pass[0] !== 1'b0) begin errors++; $display("FAIL rst_pass got=%b want=0", pass[0]); end checks++;
    cyc(0, 0, 1, 7'h01);
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL idle_nostart_busy got=%b want=0", busy[0]); end checks++;
    if (sig[0] !== 16'h0) begin errors++; $display("FAIL idle_ignore_sig got=%h want=0000", sig[0]); end checks++;
  endtask

  task automatic test_all_zero();
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL zero_busy got=%b want=1", busy[0]); end checks++;
    repeat (3) cyc(0, 0, 1, 7'h00);
    if (cnt[0] !== 16'd3) begin errors++; $display("FAIL zero_cnt3 got=%0d want=3", cnt[0]); end checks++;
    if (done[0] !== 1'b0) begin errors++; $display("FAIL zero_early_done got=%b want=0", done[0]); end checks++;
    cyc(0, 0, 1, 7'h00);
    if (done[0] !== 1'b1) begin errors++; $display("FAIL zero_done got=%b want=1", done[0]); end checks++;
    if (pass[0] !== 1'b1) begin errors++; $display("FAIL zero_pass got=%b want=1", pass[0]); end checks++;
    if (sig[0] !== 16'h0) begin errors++; $display("FAIL zero_sig got=%h want=0000", sig[0]); end checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL zero_busy_done got=%b want=0", busy[0]); end checks++;
    cyc(0, 0, 1, 7'h7F);
    if (cnt[0] !== 16'd4) begin errors++; $display("FAIL done_cnt_hold got=%0d want=4", cnt[0]); end checks++;
    if (sig[0] !== 16'h0) begin errors++; $display("FAIL done_sig_hold got=%h want=0000", sig[0]); end checks++;
    if (pass[0] !== 1'b1) begin errors++; $display("FAIL done_pass_hold got=%b want=1", pass[0]); end checks++;
    cyc(0, 1, 0, 0);
    if (done[0] !== 1'b0) begin errors++; $display("FAIL abort_done_clr got=%b want=0", done[0]); end checks++;
    if (pass[0] !== 1'b0) begin errors++; $display("FAIL abort_pass_clr got=%b want=0", pass[0]); end checks++;
    if (cnt[0] !== 16'd4) begin errors++; $display("FAIL abort_cnt_keep got=%0d want=4", cnt[0]); end checks++;
  endtask

  task automatic test_single();
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    if (done[1] !== 1'b0) begin errors++; $display("FAIL single_pre_done got=%b want=0", done[1]); end checks++;
    cyc(0, 0, 1, 7'h01);
    if (done[1] !== 1'b1) begin errors++; $display("FAIL single_done got=%b want=1", done[1]); end checks++;
    if (sig[1] !== 16'h0001) begin errors++; $display("FAIL single_sig got=%h want=0001", sig[1]); end checks++;
    if (pass[1] !== 1'b0) begin errors++; $display("FAIL single_pass got=%b want=0", pass[1]); end checks++;
    if (cnt[1] !== 16'd1) begin errors++; $display("FAIL single_cnt got=%0d want=1", cnt[1]); end checks++;
  endtask

  task automatic test_feedback();
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 7'h01);
    repeat (15) cyc(0, 0, 1, 7'h00);
    if (sig[2] !== 16'h8000) begin errors++; $display("FAIL fb_sig16 got=%h want=8000", sig[2]); end checks++;
    if (cnt[2] !== 16'd16) begin errors++; $display("FAIL fb_cnt16 got=%0d want=16", cnt[2]); end checks++;
    if (done[2] !== 1'b0) begin errors++; $display("FAIL fb_done16 got=%b want=0", done[2]); end checks++;
    cyc(0, 0, 1, 7'h00);
    if (sig[2] !== 16'h100B) begin errors++; $display("FAIL fb_sig17 got=%h want=100b", sig[2]); end checks++;
    if (done[2] !== 1'b1) begin errors++; $display("FAIL fb_done17 got=%b want=1", done[2]); end checks++;
    if (pass[2] !== 1'b0) begin errors++; $display("FAIL fb_pass got=%b want=0", pass[2]); end checks++;
  endtask

  task automatic test_valid_toggle();
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 7'h05);
    if (cnt[3] !== 16'd1) begin errors++; $display("FAIL tog_cnt1 got=%0d want=1", cnt[3]); end checks++;
    cyc(1, 0, 0, 7'h7F);
    if (cnt[3] !== 16'd1) begin errors++; $display("FAIL tog_cnt_hold got=%0d want=1", cnt[3]); end checks++;
    if (sig[3] !== 16'h0005) begin errors++; $display("FAIL tog_sig_hold got=%h want=0005", sig[3]); end checks++;
    if (busy[3] !== 1'b1) begin errors++; $display("FAIL tog_start_ignored got=%b want=1", busy[3]); end checks++;
    cyc(0, 0, 1, 7'h00);
    if (sig[3] !== 16'h000A) begin errors++; $display("FAIL tog_sig2 got=%h want=000a", sig[3]); end checks++;
    cyc(0, 0, 0, 7'h55);
    if (cnt[3] !== 16'd2) begin errors++; $display("FAIL tog_cnt2 got=%0d want=2", cnt[3]); end checks++;
    if (done[3] !== 1'b0) begin errors++; $display("FAIL tog_done_early got=%b want=0", done[3]); end checks++;
    cyc(0, 0, 1, 7'h03);
    if (cnt[3] !== 16'd3) begin errors++; $display("FAIL tog_cnt3 got=%0d want=3", cnt[3]); end checks++;
    if (sig[3] !== 16'h0017) begin errors++; $display("FAIL tog_sig3 got=%h want=0017", sig[3]); end checks++;
    if (done[3] !== 1'b1) begin errors++; $display("FAIL tog_done got=%b want=1", done[3]); end checks++;
  endtask

  task automatic test_abort();
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 7'h01);
    cyc(0, 0, 1, 7'h01);
    if (sig[0] !== 16'h0003) begin errors++; $display("FAIL abt_pre_sig got=%h want=0003", sig[0]); end checks++;
    cyc(1, 1, 1, 7'h01);
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL abt_busy got=%b want=0", busy[0]); end checks++;
    if (done[0] !== 1'b0) begin errors++; $display("FAIL abt_done got=%b want=0", done[0]); end checks++;
    if (sig[0] !== 16'h0003) begin errors++; $display("FAIL abt_sig_keep got=%h want=0003", sig[0]); end checks++;
    if (cnt[0] !== 16'd2) begin errors++; $display("FAIL abt_cnt_keep got=%0d want=2", cnt[0]); end checks++;
    cyc(0, 0, 1, 7'h01);
    if (sig[0] !== 16'h0003) begin errors++; $display("FAIL abt_idle_sig got=%h want=0003", sig[0]); end checks++;
    cyc(1, 0, 0, 0);
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL abt_restart_busy got=%b want=1", busy[0]); end checks++;
    if (sig[0] !== 16'h0) begin errors++; $display("FAIL abt_restart_sig got=%h want=0000", sig[0]); end checks++;
    if (cnt[0] !== 16'd0) begin errors++; $display("FAIL abt_restart_cnt got=%0d want=0", cnt[0]); end checks++;
  endtask

  task automatic test_rst_mid();
    cyc(0, 0, 1, 7'h01);
    cyc(0, 0, 1, 7'h01);
    if (cnt[0] !== 16'd2) begin errors++; $display("FAIL rstm_pre_cnt got=%0d want=2", cnt[0]); end checks++;
    @(negedge clk);
    start = 0; abort = 0; resp_valid = 0;
    #2 rst = 1'b1;
    #1;
    if (sig[0] !== 16'h0) begin errors++; $display("FAIL rstm_sig got=%h want=0000", sig[0]); end checks++;
    if (cnt[0] !== 16'd0) begin errors++; $display("FAIL rstm_cnt got=%0d want=0", cnt[0]); end checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL rstm_busy got=%b want=0", busy[0]); end checks++;
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 1, 7'h01);
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL rstm_nostart got=%b want=0", busy[0]); end checks++;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 7'h01);
    if (sig[0] !== 16'h0001) begin errors++; $display("FAIL rstm_restart_sig got=%h want=0001", sig[0]); end checks++;
  endtask

  task automatic test_back_to_back();
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 7'h01);
    cyc(0, 0, 1, 7'h03);
    if (sig[4] !== 16'h0001) begin errors++; $display("FAIL b2b_sig got=%h want=0001", sig[4]); end checks++;
    if (done[4] !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b want=1", done[4]); end checks++;
    cyc(1, 0, 1, 7'h7F);
    if (sig[4] !== 16'h0) begin errors++; $display("FAIL b2b_reload_sig got=%h want=0000", sig[4]); end checks++;
    if (done[4] !== 1'b0) begin errors++; $display("FAIL b2b_reload_done got=%b want=0", done[4]); end checks++;
    repeat (2) cyc(0, 0, 1, 7'h00);
    if (pass[4] !== 1'b1) begin errors++; $display("FAIL b2b_pass got=%b want=1", pass[4]); end checks++;
  endtask

`ifdef MISR_XMASK_EN
  task automatic test_mask();
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    resp_mask = 7'h7F;
    repeat (2) cyc(0, 0, 1, 7'h7F);
    if (sig[4] !== 16'h0) begin errors++; $display("FAIL mask_sig got=%h want=0000", sig[4]); end checks++;
    if (pass[4] !== 1'b1) begin errors++; $display("FAIL mask_pass got=%b want=1", pass[4]); end checks++;
    resp_mask = 7'h00;
  endtask
`endif

  initial begin
    rst = 1'b1; start = 0; abort = 0; resp_valid = 0; resp = '0;
`ifdef MISR_XMASK_EN
    resp_mask = '0;
`endif
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_reset();
    test_all_zero();
    test_single();
    test_feedback();
    test_valid_toggle();
    test_abort();
    test_rst_mid();
    test_back_to_back();
`ifdef MISR_XMASK_EN
    test_mask();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/misr_compactor.md
MISR_COMPACTOR -- requirements
Module: misr_compactor

Interface
REQ-001 The block SHALL have parameter SIG_W, default 16, meaning signature register width.
REQ-002 The block SHALL have parameter IN_W, default 7, meaning CUT response width (IN_W <= SIG_W).
REQ-003 The block SHALL have parameter NUM_PAT, default 1000, meaning responses compacted per session (1..65535).
REQ-004 The block SHALL have parameter GOLDEN, default 16'h0000, meaning expected final signature.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: begin a session.
REQ-008 The block SHALL have port abort, input, 1 bit: cancel a session and return to IDLE.
REQ-009 The block SHALL have port resp_valid, input, 1 bit: resp holds one CUT response this cycle.
REQ-010 The block SHALL have port resp, input, IN_W bits: CUT output vector.
REQ-011 The block SHALL have port busy, output, 1 bit: high in COMPACT.
REQ-012 The block SHALL have port done, output, 1 bit: high in DONE.
REQ-013 The block SHALL have port pass, output, 1 bit: signature == GOLDEN; meaningful only while done.
REQ-014 The block SHALL have port signature, output, SIG_W bits: current MISR contents.
REQ-015 The block SHALL have port pat_cnt, output, 16 bits: responses compacted this session.

Function
REQ-016 The FSM SHALL have states IDLE, COMPACT and DONE.
REQ-017 In IDLE or DONE, start=1 SHALL load signature=0 and pat_cnt=0 and enter COMPACT on the next edge.
REQ-018 In COMPACT, start SHALL be ignored.
REQ-019 In COMPACT with resp_valid=1, the MISR SHALL update as {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended resp.
REQ-020 POLY SHALL be 16'h100B, i.e. x^16+x^12+x^3+x+1.
REQ-021 Each compaction SHALL increment pat_cnt by 1.
REQ-022 With resp_valid=0, signature and pat_cnt SHALL hold.
REQ-023 The edge that compacts response number NUM_PAT SHALL also enter DONE, so done rises one cycle after the last valid response.
REQ-024 pass SHALL be registered on entry to DONE from the final signature.
REQ-025 DONE SHALL hold signature, pat_cnt, done and pass until start, abort or rst.
REQ-026 resp_valid SHALL be ignored in IDLE and DONE.
REQ-027 abort=1 in any state SHALL enter IDLE, clear done and pass, and retain signature and pat_cnt.
REQ-028 abort SHALL take priority over start and resp_valid in the same cycle.
REQ-029 pat_cnt SHALL never exceed NUM_PAT.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, signature=0, pat_cnt=0, busy=0, done=0 and pass=0, including mid-session.
REQ-031 After rst deasserts, the first session SHALL require a start.

Configuration
REQ-032 MISR_XMASK_EN defined SHALL add input resp_mask, IN_W bits, and compact resp & ~resp_mask, so masked unknown bits never reach the MISR.
REQ-033 Without MISR_XMASK_EN, resp_mask SHALL be absent and resp SHALL be compacted unmasked.

Structure
REQ-034 Package bist_pkg SHALL hold the MISR_POLY16 constant, the misr_state_e typedef (IDLE/COMPACT/DONE) and the pattern counter width constant.
REQ-035 Sub-module misr_core SHALL hold the pure MISR register with load-zero and enable inputs.
REQ-036 The FSM, counter and comparator SHALL live in misr_compactor.

Verification
REQ-037 NUM_PAT=4, resp=0 for all patterns -> signature=16'h0000, done after 4 valid cycles, pass=1 with GOLDEN=0.
REQ-038 NUM_PAT=1, resp=7'h01 -> signature=16'h0001, done one cycle later, pass=0 with GOLDEN=0.
REQ-039 NUM_PAT=17, resp=7'h01 then 16 zeros -> signature=16'h8000 after pattern 16 and 16'h100B after pattern 17 (feedback path).
REQ-040 resp_valid toggled 1/0 with NUM_PAT=3 -> pat_cnt advances only on valid cycles; done after the third valid response.
REQ-041 abort, and separately rst, asserted after 2 of 4 patterns -> abort: IDLE with done=0 and signature retained; rst: all outputs zero; a later start restarts with signature=0.
REQ-042 MISR_XMASK_EN defined, resp=7'h7F, resp_mask=7'h7F, NUM_PAT=2 -> signature=16'h0000.
